// File: rtl/muldiv_pkg.sv
// Shared types and default latencies for the multiply/divide sequencer.
// Optional build macro: MULDIV_EARLY_ZERO_EN (see muldiv_ctrl).
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAPT,
    DONE
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_DIV_LAT  = 32;
  localparam int DEF_MULT_LAT = 33;
  localparam int DEF_CNT_W    = 6;

endpackage

// File: rtl/muldiv_if.sv
// Request, result and unit-side signals of the multiply/divide sequencer.
// master = CPU control plus units, slave = muldiv_ctrl.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic [WIDTH-1:0] unit_a;
  logic [WIDTH-1:0] unit_b;
  logic             div_ctrl;
  logic             mult_ctrl;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic             div_excp;
  logic [WIDTH-1:0] mult_hi;
  logic [WIDTH-1:0] mult_lo;

  modport master (
    output start, op, rs_val, rt_val,
    output div_quo, div_rem, div_excp,
    output mult_hi, mult_lo,
    input  busy, done, div_zero,
    input  hi_out, lo_out, unit_a, unit_b,
    input  div_ctrl, mult_ctrl
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    input  div_quo, div_rem, div_excp,
    input  mult_hi, mult_lo,
    output busy, done, div_zero,
    output hi_out, lo_out, unit_a, unit_b,
    output div_ctrl, mult_ctrl
  );
endinterface

// File: rtl/muldiv_lat_counter.sv
// Loadable down-counter; last is high while the count equals one.
module muldiv_lat_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared iterative multiply/divide units.
// MULDIV_EARLY_ZERO_EN: finish a zero-divisor DIV straight from IDLE.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             dctl_q, dctl_d;
  logic             mctl_q, mctl_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_last;
  logic             early_zero;

`ifdef MULDIV_EARLY_ZERO_EN
  assign early_zero = (bus.op == OP_DIV) && (bus.rt_val == '0);
`else
  assign early_zero = 1'b0;
`endif

  muldiv_lat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (reset),
    .load    (cnt_load),
    .load_val(cnt_val),
    .dec     (state_q == RUN),
    .last    (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dz_d     = dz_q;
    dctl_d   = dctl_q;
    mctl_d   = mctl_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_d      = a_q;
    b_d      = b_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    unique case (state_q)
      IDLE: begin
        // the done cycle still counts as busy, so start waits for it
        if (bus.start && !done_q) begin
          a_d  = bus.rs_val;
          b_d  = bus.rt_val;
          op_d = op_t'(bus.op);
          dz_d = 1'b0;
          if (early_zero) begin
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            cnt_load = 1'b1;
            cnt_val  = (bus.op == OP_DIV) ? CNT_W'(DIV_LAT)
                                          : CNT_W'(MULT_LAT);
            dctl_d   = (bus.op == OP_DIV);
            mctl_d   = (bus.op == OP_MULT);
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (op_q == OP_DIV && bus.div_excp) begin
          dctl_d  = 1'b0;
          dz_d    = 1'b1;
          state_d = DONE;
        end else if (cnt_last) begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        if (op_q == OP_DIV) begin
          hi_d = bus.div_rem;
          lo_d = bus.div_quo;
        end else begin
          hi_d = bus.mult_hi;
          lo_d = bus.mult_lo;
        end
        dctl_d  = 1'b0;
        mctl_d  = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      dctl_q  <= 1'b0;
      mctl_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      dctl_q  <= dctl_d;
      mctl_q  <= mctl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.div_zero  = dz_q;
  assign bus.div_ctrl  = dctl_q;
  assign bus.mult_ctrl = mctl_q;
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;
  assign bus.unit_a    = a_q;
  assign bus.unit_b    = b_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with behavioural iterative units.
// Honours MULDIV_EARLY_ZERO_EN when the design is built with it.
module tb_muldiv_ctrl;

  localparam int DIV_LAT  = 32;
  localparam int MULT_LAT = 33;
`ifdef MULDIV_EARLY_ZERO_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(
    .WIDTH   (32),
    .DIV_LAT (DIV_LAT),
    .MULT_LAT(MULT_LAT),
    .CNT_W   (6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Iterative units: outputs become valid only after LAT enabled edges.
  int dcnt = 0;
  int mcnt = 0;
  always @(posedge clk) begin
    dcnt <= bus.div_ctrl ? dcnt + 1 : 0;
    mcnt <= bus.mult_ctrl ? mcnt + 1 : 0;
  end

  int     ua, ub, uq, ur;
  longint up;
  always_comb begin
    ua = bus.unit_a;
    ub = bus.unit_b;
    uq = 0;
    ur = 0;
    if (ub != 0) begin
      uq = ua / ub;
      ur = ua % ub;
    end
    up = longint'(ua) * longint'(ub);
  end

  assign bus.div_quo  = (dcnt >= DIV_LAT) ? uq : 32'hDEADBEEF;
  assign bus.div_rem  = (dcnt >= DIV_LAT) ? ur : 32'hDEADBEEF;
  assign bus.div_excp = bus.div_ctrl && dcnt >= 1 && bus.unit_b == 0;
  assign bus.mult_hi  = (mcnt >= MULT_LAT) ? up[63:32] : 32'hBAADF00D;
  assign bus.mult_lo  = (mcnt >= MULT_LAT) ? up[31:0] : 32'hBAADF00D;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: result from plain signed arithmetic, zero divisor keeps HI/LO.
  task automatic ref_model(input logic opv, input logic [31:0] a, b,
                           output logic [31:0] eh, el, output logic ez);
    int     sa, sb;
    longint p;
    sa = a;
    sb = b;
    ez = 1'b0;
    if (opv && b == 0) begin
      eh = ref_hi;
      el = ref_lo;
      ez = 1'b1;
    end else if (opv) begin
      eh = sa % sb;
      el = sa / sb;
    end else begin
      p  = longint'(sa) * longint'(sb);
      eh = p[63:32];
      el = p[31:0];
    end
  endtask

  task automatic run_op(input logic opv, input logic [31:0] a, b,
                        input logic [31:0] eh, el, input logic ez,
                        input string nm, input bit inject);
    int   done_k = -1;
    int   ndone = 0;
    int   last_on = -1;
    int   other_on = 0;
    int   lat, exp_last;
    logic zero;
    logic busy_end;
    zero = opv && b == 0;
    if (zero) begin
      lat      = EARLY ? 1 : 3;
      exp_last = EARLY ? -1 : 1;
    end else begin
      lat      = (opv ? DIV_LAT : MULT_LAT) + 2;
      exp_last = lat - 2;
    end
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = opv;
    bus.rs_val = a;
    bus.rt_val = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({nm, " busy_e0"}, bus.busy, 1);
    chk({nm, " unit_a_e0"}, bus.unit_a, a);
    chk({nm, " unit_b_e0"}, bus.unit_b, b);
    busy_end = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (inject && k == 4) begin
        bus.start  = 1'b1;
        bus.op     = 1'b0;
        bus.rs_val = 32'd3;
        bus.rt_val = 32'd5;
      end
      if (inject && k == 5) bus.start = 1'b0;
      if (opv ? bus.div_ctrl : bus.mult_ctrl) last_on = k;
      if (opv ? bus.mult_ctrl : bus.div_ctrl) other_on++;
      if (bus.done) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      busy_end = bus.busy;
      if (done_k >= 0 && k == done_k + 2) break;
    end
    chk({nm, " done_edge"}, done_k, lat);
    chk({nm, " done_pulses"}, ndone, 1);
    chk({nm, " ctrl_last_edge"}, last_on, exp_last);
    chk({nm, " other_ctrl"}, other_on, 0);
    chk({nm, " hi"}, bus.hi_out, eh);
    chk({nm, " lo"}, bus.lo_out, el);
    chk({nm, " div_zero"}, bus.div_zero, ez);
    chk({nm, " busy_end"}, busy_end, 0);
    chk({nm, " unit_a_end"}, bus.unit_a, a);
    ref_hi = eh;
    ref_lo = el;
  endtask

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    logic        ez;
    string       nm;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] ra, rb, eh, el;
    logic        ro, ez;
    int          nd;

    tbl[0] = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "div100_7"};
    tbl[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD,
               1'b0, "div_m7_2"};
    tbl[2] = '{1'b0, 32'h00010000, 32'h00010000, 32'd1, 32'd0,
               1'b0, "mul_2p32"};
    tbl[3] = '{1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, "mul_3_5"};
    tbl[4] = '{1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
               1'b0, "mul_m1_1"};
    tbl[5] = '{1'b1, 32'h5555AAAA, 32'h00010000, 32'h0000AAAA,
               32'h00005555, 1'b0, "div_preload"};

    bus.start  = 1'b0;
    bus.op     = 1'b0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    reset      = 1'b1;
    #12;
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst div_zero", bus.div_zero, 0);
    chk("rst ctrls", {bus.div_ctrl, bus.mult_ctrl}, 0);
    chk("rst hi_lo", {bus.hi_out, bus.lo_out}, 0);
    chk("rst units", {bus.unit_a, bus.unit_b}, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el,
             tbl[i].ez, tbl[i].nm, 1'b0);

    run_op(1'b1, 32'd5, 32'd0, 32'h0000AAAA, 32'h00005555, 1'b1,
           "div5_0", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("div_zero_hold", bus.div_zero, 1);

    run_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "restart_ign", 1'b1);

    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = 1'b1;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst div_ctrl", bus.div_ctrl, 0);
    chk("midrst busy", bus.busy, 0);
    chk("midrst hi_lo", {bus.hi_out, bus.lo_out}, 0);
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    ref_hi = '0;
    ref_lo = '0;
    nd     = 0;
    repeat (45) begin
      @(posedge clk);
      #1;
      if (bus.done) nd++;
    end
    chk("midrst no_done", nd, 0);
    run_op(1'b1, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, "div9_3", 1'b0);

    for (int i = 0; i < 12; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(1, 100);
        1: rb = 32'd0;
        default: rb = $urandom;
      endcase
      if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd1;
      ref_model(ro, ra, rb, eh, el, ez);
      run_op(ro, ra, rb, eh, el, ez, $sformatf("rnd%0d", i), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
